// File: rtl/msa_insn_encoder_if.sv
// Request/response bundle for the MSA instruction encoder.
// The master side drives requests and consumes words; the slave side is the encoder.
interface msa_insn_encoder_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_fmt;
  logic [4:0]    in_op;
  logic [1:0]    in_df;
  logic [4:0]    in_wt;
  logic [4:0]    in_ws;
  logic [4:0]    in_wd;
  logic [15:0]   in_imm;
  logic [5:0]    in_minor;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_word;
  logic          err_fmt;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_fmt, in_op, in_df, in_wt, in_ws, in_wd, in_imm, in_minor,
    output out_ready,
    input  in_ready, out_valid, out_word, err_fmt, count
  );

  modport slave (
    input  in_valid, in_fmt, in_op, in_df, in_wt, in_ws, in_wd, in_imm, in_minor,
    input  out_ready,
    output in_ready, out_valid, out_word, err_fmt, count
  );
endinterface

// File: rtl/msa_insn_encoder.sv
// Encodes decoded MSA/branch field bundles into 32-bit instruction words and
// buffers them in a DEPTH-entry FIFO feeding the instruction-memory loader.
module msa_insn_encoder #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  msa_insn_encoder_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [5:0]    MSA_MAJOR = 6'b011110;

  typedef enum logic [3:0] {
    FMT_I8     = 4'd0,
    FMT_I5     = 4'd1,
    FMT_I10    = 4'd2,
    FMT_BIT    = 4'd3,
    FMT_3R     = 4'd4,
    FMT_ELM    = 4'd5,
    FMT_3RF    = 4'd6,
    FMT_2R     = 4'd7,
    FMT_2RF    = 4'd8,
    FMT_VEC    = 4'd9,
    FMT_MI10   = 4'd10,
    FMT_BRANCH = 4'd11
  } fmt_e;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          err_q;
  logic [31:0]   enc_word;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic          out_valid_c;

  // Handshake decode: readiness depends only on occupancy.
  always_comb begin
    bus.in_ready = (count_q != FULL);
    out_valid_c  = (count_q != '0);
    accept       = bus.in_valid && bus.in_ready;
    push         = accept && legal;
    pop          = out_valid_c && bus.out_ready;
  end

  // Field packing per instruction format; fmt 12..15 flagged illegal.
  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (bus.in_fmt)
      FMT_I8:     enc_word = {MSA_MAJOR, bus.in_op[1:0], bus.in_imm[7:0], bus.in_ws, bus.in_wd, bus.in_minor};
      FMT_I5:     enc_word = {MSA_MAJOR, bus.in_op[2:0], bus.in_df, bus.in_imm[4:0], bus.in_ws, bus.in_wd, bus.in_minor};
      FMT_I10:    enc_word = {MSA_MAJOR, bus.in_op[2:0], bus.in_df, bus.in_imm[9:0], bus.in_wd, bus.in_minor};
      FMT_BIT:    enc_word = {MSA_MAJOR, bus.in_op[2:0], bus.in_imm[6:0], bus.in_ws, bus.in_wd, bus.in_minor};
      FMT_3R:     enc_word = {MSA_MAJOR, bus.in_op[2:0], bus.in_df, bus.in_wt, bus.in_ws, bus.in_wd, bus.in_minor};
      FMT_ELM:    enc_word = {MSA_MAJOR, bus.in_op[3:0], bus.in_imm[5:0], bus.in_ws, bus.in_wd, bus.in_minor};
      FMT_3RF:    enc_word = {MSA_MAJOR, bus.in_op[3:0], bus.in_df[0], bus.in_wt, bus.in_ws, bus.in_wd, bus.in_minor};
      FMT_2R:     enc_word = {MSA_MAJOR, 5'b11000, bus.in_op[2:0], bus.in_df, bus.in_ws, bus.in_wd, 6'b011110};
      FMT_2RF:    enc_word = {MSA_MAJOR, 5'b11001, bus.in_op[3:0], bus.in_df[0], bus.in_ws, bus.in_wd, 6'b011110};
      FMT_VEC:    enc_word = {MSA_MAJOR, bus.in_op, bus.in_wt, bus.in_ws, bus.in_wd, 6'b011110};
      FMT_MI10:   enc_word = {MSA_MAJOR, bus.in_imm[9:0], bus.in_ws, bus.in_wd, bus.in_minor};
      FMT_BRANCH: enc_word = {6'b010001, bus.in_op, bus.in_wt, bus.in_imm};
      default:    legal    = 1'b0;
    endcase
  end

  // FIFO storage, pointers, occupancy and illegal-format pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      err_q <= accept && !legal;
    end
  end

  // Output view: head word gated to zero while empty.
  always_comb begin
    bus.out_valid = out_valid_c;
    bus.out_word  = out_valid_c ? mem[rd_ptr] : '0;
    bus.err_fmt   = err_q;
    bus.count     = count_q;
  end
endmodule

// File: tb/tb_msa_insn_encoder.sv
// Directed + short random bench for msa_insn_encoder with a word scoreboard.
module tb_msa_insn_encoder;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  fmt;
    logic [4:0]  op;
    logic [1:0]  df;
    logic [4:0]  wt;
    logic [4:0]  ws;
    logic [4:0]  wd;
    logic [15:0] imm;
    logic [5:0]  minor;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  msa_insn_encoder_if #(.DEPTH(DEPTH)) bus ();
  msa_insn_encoder #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [31:0] q[$];
  int mcount = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic [3:0] f, input logic [4:0] op, input logic [1:0] df,
                              input logic [4:0] wt, input logic [4:0] ws, input logic [4:0] wd,
                              input logic [15:0] imm, input logic [5:0] minor);
    req_t r;
    r.fmt = f; r.op = op; r.df = df; r.wt = wt; r.ws = ws; r.wd = wd; r.imm = imm; r.minor = minor;
    return r;
  endfunction

  function automatic logic [31:0] enc(input req_t r);
    logic [31:0] w;
    case (r.fmt)
      4'd0:  w = {6'b011110, r.op[1:0], r.imm[7:0], r.ws, r.wd, r.minor};
      4'd1:  w = {6'b011110, r.op[2:0], r.df, r.imm[4:0], r.ws, r.wd, r.minor};
      4'd2:  w = {6'b011110, r.op[2:0], r.df, r.imm[9:0], r.wd, r.minor};
      4'd3:  w = {6'b011110, r.op[2:0], r.imm[6:0], r.ws, r.wd, r.minor};
      4'd4:  w = {6'b011110, r.op[2:0], r.df, r.wt, r.ws, r.wd, r.minor};
      4'd5:  w = {6'b011110, r.op[3:0], r.imm[5:0], r.ws, r.wd, r.minor};
      4'd6:  w = {6'b011110, r.op[3:0], r.df[0], r.wt, r.ws, r.wd, r.minor};
      4'd7:  w = {6'b011110, 5'b11000, r.op[2:0], r.df, r.ws, r.wd, 6'b011110};
      4'd8:  w = {6'b011110, 5'b11001, r.op[3:0], r.df[0], r.ws, r.wd, 6'b011110};
      4'd9:  w = {6'b011110, r.op, r.wt, r.ws, r.wd, 6'b011110};
      4'd10: w = {6'b011110, r.imm[9:0], r.ws, r.wd, r.minor};
      4'd11: w = {6'b010001, r.op, r.wt, r.imm};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic req_t rnd_req();
    return mk(4'($urandom_range(0, 15)), 5'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 16'($urandom), 6'($urandom));
  endfunction

  // One clock cycle: drive at negedge, check against model, advance to next negedge.
  task automatic step(input logic v, input req_t r, input logic rdy, input logic rst);
    logic acc, pp, err_exp;
    bus.in_valid = v; bus.in_fmt = r.fmt; bus.in_op = r.op; bus.in_df = r.df;
    bus.in_wt = r.wt; bus.in_ws = r.ws; bus.in_wd = r.wd; bus.in_imm = r.imm;
    bus.in_minor = r.minor; bus.out_ready = rdy; reset = rst;
    #1;
    chk("count", 32'(bus.count), 32'(mcount));
    chk("in_ready", 32'(bus.in_ready), 32'(mcount != DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(mcount != 0));
    if (mcount == 0) chk("out_word_empty", bus.out_word, 32'h0);
    acc = v && (mcount != DEPTH);
    pp  = rdy && (mcount != 0);
    if (pp) begin
      if (q.size() == 0) chk("scoreboard_underrun", 32'h1, 32'h0);
      else chk("out_word", bus.out_word, q.pop_front());
    end
    if (acc && r.fmt <= 4'd11) begin
      q.push_back(enc(r));
      mcount++;
    end
    if (pp) mcount--;
    err_exp = acc && (r.fmt >= 4'd12);
    if (rst) begin
      q.delete();
      mcount = 0;
      err_exp = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("err_fmt", 32'(bus.err_fmt), 32'(err_exp));
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (mcount != 0 && n < 4 * DEPTH) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_done", 32'(mcount), 32'h0);
  endtask

  req_t r_i8, r_3r, r_br, r_2r, r_vec, r_bad;

  initial begin
    r_i8  = mk(4'd0, 5'd1, 2'd0, 5'd0, 5'd3, 5'd4, 16'h00A5, 6'h01);
    r_3r  = mk(4'd4, 5'd0, 2'd2, 5'd1, 5'd2, 5'd3, 16'h0000, 6'b001110);
    r_br  = mk(4'd11, 5'h08, 2'd0, 5'd0, 5'd0, 5'd0, 16'h0004, 6'h00);
    r_2r  = mk(4'd7, 5'd0, 2'd1, 5'd0, 5'd5, 5'd6, 16'h0000, 6'h00);
    r_vec = mk(4'd9, 5'h15, 2'd3, 5'd7, 5'd8, 5'd9, 16'hFFFF, 6'h3F);
    r_bad = mk(4'hD, 5'h1F, 2'd3, 5'd1, 5'd1, 5'd1, 16'h1234, 6'h2A);

    bus.in_valid = 1'b0; bus.in_fmt = '0; bus.in_op = '0; bus.in_df = '0; bus.in_wt = '0;
    bus.in_ws = '0; bus.in_wd = '0; bus.in_imm = '0; bus.in_minor = '0; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_word", bus.out_word, 32'h0);
    chk("rst_err_fmt", 32'(bus.err_fmt), 32'h0);
    reset = 1'b0;

    // Reference vectors, latency and fill to full.
    step(1'b1, r_i8, 1'b0, 1'b0);
    chk("i8_word", bus.out_word, 32'h79A51901);
    chk("i8_count", 32'(bus.count), 32'h1);
    step(1'b1, r_3r, 1'b0, 1'b0);
    step(1'b1, r_br, 1'b0, 1'b0);
    step(1'b1, r_2r, 1'b0, 1'b0);
    chk("full_count", 32'(bus.count), 32'(DEPTH));
    chk("full_in_ready", 32'(bus.in_ready), 32'h0);
    step(1'b1, r_vec, 1'b0, 1'b0);
    chk("held_count", 32'(bus.count), 32'(DEPTH));
    chk("held_word", bus.out_word, 32'h79A51901);
    step(1'b1, r_vec, 1'b1, 1'b0);
    chk("3r_word", bus.out_word, 32'h784110CE);
    chk("in_ready_after_pop", 32'(bus.in_ready), 32'h1);
    step(1'b1, r_vec, 1'b1, 1'b0);
    chk("branch_word", bus.out_word, 32'h45000004);
    step(1'b1, r_i8, 1'b1, 1'b0);
    chk("2r_word", bus.out_word, 32'h7B01299E);

    // Sustained push+pop near full; pointers wrap.
    for (int i = 0; i < 8; i++) begin
      req_t r;
      r = rnd_req();
      r.fmt = 4'(i % 12);
      step(1'b1, r, 1'b1, 1'b0);
    end
    drain();

    // Illegal format: pulse only, nothing stored.
    step(1'b1, r_bad, 1'b0, 1'b0);
    chk("bad_count", 32'(bus.count), 32'h0);
    step(1'b0, r_bad, 1'b0, 1'b0);
    step(1'b1, r_3r, 1'b0, 1'b0);
    step(1'b1, r_bad, 1'b1, 1'b0);
    drain();

    // Reset with three words buffered and a push/pop in flight.
    step(1'b1, r_br, 1'b0, 1'b0);
    step(1'b1, r_2r, 1'b0, 1'b0);
    step(1'b1, r_vec, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'h3);
    step(1'b1, r_i8, 1'b1, 1'b1);
    chk("post_rst_count", 32'(bus.count), 32'h0);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("post_rst_out_word", bus.out_word, 32'h0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom), rnd_req(), 1'($urandom), 1'b0);
    end
    drain();
    chk("final_count", 32'(bus.count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
